// File: rtl/neuro_datapath_if.sv
// Handshake bundle between an initiating control FSM and the neuro datapath.
// The initiator drives start/instruction; the datapath answers with finished/result.
interface neuro_datapath_if #(
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int RESULT_WIDTH      = 32
);
    logic                         start;
    logic [INSTRUCTION_WIDTH-1:0] instruction;
    logic                         finished;
    logic [RESULT_WIDTH-1:0]      result;

    modport master (output start, output instruction, input finished, input result);
    modport slave  (input start, input instruction, output finished, output result);
endinterface

// File: rtl/neuro_datapath.sv
// Instruction-driven datapath: operand registers, accumulator with serial signed MAC,
// and a Galois LFSR for mutation randomness, answering a start/finished handshake.
module neuro_datapath #(
    parameter int          INSTRUCTION_WIDTH = 32,
    parameter int          RESULT_WIDTH      = 32,
    parameter int          DATA_WIDTH        = 16,
    parameter logic [31:0] LFSR_SEED         = 32'h0000_0001
) (
    input logic             clock,
    input logic             resetn,
    neuro_datapath_if.slave bus
);
    localparam int              CNT_W     = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] MUL_DONE = CNT_W'(DATA_WIDTH);
    localparam logic [31:0]     LFSR_TAPS = 32'h8020_0003;

    localparam logic [3:0] OP_NOP    = 4'd0;
    localparam logic [3:0] OP_LOAD_A = 4'd1;
    localparam logic [3:0] OP_LOAD_B = 4'd2;
    localparam logic [3:0] OP_CLR    = 4'd3;
    localparam logic [3:0] OP_ADD    = 4'd4;
    localparam logic [3:0] OP_MAC    = 4'd5;
    localparam logic [3:0] OP_READ   = 4'd6;
    localparam logic [3:0] OP_RAND   = 4'd7;

    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_MUL, ST_RNG} state_t;

    state_t state, state_next;
    logic   start_q;
    logic   accept;

    logic [INSTRUCTION_WIDTH-1:0] instr_q;
    logic [3:0]                   opcode_in;
    logic [3:0]                   opcode_q;
    logic [DATA_WIDTH-1:0]        operand_q;
    logic                         unused_operand_bits;

    logic signed [DATA_WIDTH-1:0]   reg_a;
    logic signed [DATA_WIDTH-1:0]   reg_b;
    logic signed [RESULT_WIDTH-1:0] acc;
    logic signed [RESULT_WIDTH-1:0] acc_add;
    logic signed [RESULT_WIDTH-1:0] acc_mac;
    logic [31:0]                    lfsr;
    logic                           finished_q;
    logic [RESULT_WIDTH-1:0]        result_q;

    // Private multiplier and RNG working state; architectural registers only change on commit
    logic signed [RESULT_WIDTH-1:0] mul_mcand;
    logic signed [RESULT_WIDTH-1:0] mul_prod;
    logic [DATA_WIDTH-1:0]          mul_mplier;
    logic [CNT_W-1:0]               mul_cnt;
    logic [31:0]                    rng_work;
    logic [4:0]                     rng_left;

    function automatic logic signed [RESULT_WIDTH-1:0] sext_data(input logic signed [DATA_WIDTH-1:0] v);
        return {{(RESULT_WIDTH-DATA_WIDTH){v[DATA_WIDTH-1]}}, v};
    endfunction

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_TAPS : 32'h0);
    endfunction

    assign opcode_in           = bus.instruction[INSTRUCTION_WIDTH-1 -: 4];
    assign opcode_q            = instr_q[INSTRUCTION_WIDTH-1 -: 4];
    assign operand_q           = instr_q[DATA_WIDTH-1:0];
    assign unused_operand_bits = ^instr_q[INSTRUCTION_WIDTH-5:DATA_WIDTH];
    assign acc_add             = acc + sext_data(reg_a);
    assign acc_mac             = acc + mul_prod;
    assign bus.finished        = finished_q;
    assign bus.result          = result_q;

    always_ff @(posedge clock) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                // Only a rising edge of start launches work; a held request is one request
                if (bus.start && !start_q) begin
                    accept = 1'b1;
                    if (opcode_in == OP_MAC)       state_next = ST_MUL;
                    else if (opcode_in == OP_RAND) state_next = ST_RNG;
                    else                           state_next = ST_EXEC;
                end
            end
            ST_EXEC: state_next = ST_IDLE;
            ST_MUL:  if (mul_cnt == MUL_DONE) state_next = ST_IDLE;
            ST_RNG:  if (rng_left == 5'd0) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            start_q    <= 1'b1;
            finished_q <= 1'b1;
            result_q   <= '0;
            reg_a      <= '0;
            reg_b      <= '0;
            acc        <= '0;
            lfsr       <= LFSR_SEED;
        end else begin
            start_q <= bus.start;
            if (accept) finished_q <= 1'b0;
            case (state)
                ST_EXEC: begin
                    finished_q <= 1'b1;
                    case (opcode_q)
                        OP_NOP:    result_q <= '0;
                        OP_LOAD_A: begin reg_a <= operand_q; result_q <= sext_data(operand_q); end
                        OP_LOAD_B: begin reg_b <= operand_q; result_q <= sext_data(operand_q); end
                        OP_CLR:    begin acc <= '0; result_q <= '0; end
                        OP_ADD:    begin acc <= acc_add; result_q <= acc_add; end
                        OP_READ:   result_q <= acc;
                        default:   result_q <= '1;
                    endcase
                end
                ST_MUL: begin
                    if (mul_cnt == MUL_DONE) begin
                        acc        <= acc_mac;
                        result_q   <= acc_mac;
                        finished_q <= 1'b1;
                    end
                end
                ST_RNG: begin
                    if (rng_left == 5'd0) begin
                        lfsr       <= lfsr_step(rng_work);
                        result_q   <= RESULT_WIDTH'(lfsr_step(rng_work));
                        finished_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Shift-add over B's bits; the top bit carries negative weight for two's complement
    always_ff @(posedge clock) begin
        if (accept) begin
            instr_q    <= bus.instruction;
            mul_mcand  <= sext_data(reg_a);
            mul_mplier <= reg_b;
            mul_prod   <= '0;
            mul_cnt    <= '0;
            rng_work   <= lfsr;
            rng_left   <= bus.instruction[4:0];
        end else begin
            if (state == ST_MUL && mul_cnt != MUL_DONE) begin
                if (mul_mplier[0])
                    mul_prod <= (mul_cnt == MUL_LAST) ? mul_prod - mul_mcand : mul_prod + mul_mcand;
                mul_mcand  <= mul_mcand <<< 1;
                mul_mplier <= mul_mplier >> 1;
                mul_cnt    <= mul_cnt + 1'b1;
            end
            if (state == ST_RNG) begin
                rng_work <= lfsr_step(rng_work);
                rng_left <= rng_left - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_neuro_datapath.sv
// Directed and randomized checks of neuro_datapath against an arithmetic reference model.
module tb_neuro_datapath;
    logic clock;
    logic resetn;
    int   errors = 0;
    int   checks = 0;

    logic [15:0] m_a, m_b;
    logic [31:0] m_acc, m_lfsr;

    neuro_datapath_if #(.INSTRUCTION_WIDTH(32), .RESULT_WIDTH(32)) dp_bus ();

    neuro_datapath dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (dp_bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_a = 16'h0; m_b = 16'h0; m_acc = 32'h0; m_lfsr = 32'h0000_0001;
    endtask

    // Reference behaviour: what each opcode does to the architectural state
    task automatic model_exec(input logic [3:0] opc, input logic [27:0] opnd,
                              output logic [31:0] res, output int lat);
        int pa, pb, n;
        lat = 1;
        case (opc)
            4'd0: res = 32'h0;
            4'd1: begin m_a = opnd[15:0]; pa = $signed(m_a); res = pa; end
            4'd2: begin m_b = opnd[15:0]; pb = $signed(m_b); res = pb; end
            4'd3: begin m_acc = 32'h0; res = 32'h0; end
            4'd4: begin pa = $signed(m_a); m_acc = m_acc + pa; res = m_acc; end
            4'd5: begin
                pa = $signed(m_a); pb = $signed(m_b);
                m_acc = m_acc + pa * pb; res = m_acc; lat = 17;
            end
            4'd6: res = m_acc;
            4'd7: begin
                n = int'(opnd[4:0]) + 1;
                for (int i = 0; i < n; i++)
                    m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 32'h8020_0003 : 32'h0);
                res = m_lfsr; lat = n;
            end
            default: res = 32'hFFFF_FFFF;
        endcase
    endtask

    task automatic do_reset(input string tag);
        @(negedge clock);
        resetn = 1'b0; dp_bus.start = 1'b0;
        @(posedge clock); @(posedge clock); #1;
        chk({tag, "_finished"}, 32'(dp_bus.finished), 32'd1);
        chk({tag, "_result"}, dp_bus.result, 32'h0);
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock);
        model_reset();
    endtask

    // mode 1 raises start again while the operation is busy
    task automatic run_op(input logic [3:0] opc, input logic [27:0] opnd, input string tag, input int mode);
        logic [31:0] exp_res;
        int          exp_lat;
        int          lat;
        model_exec(opc, opnd, exp_res, exp_lat);
        @(negedge clock);
        dp_bus.instruction = {opc, opnd};
        dp_bus.start = 1'b1;
        @(posedge clock); #1;
        chk({tag, "_busy"}, 32'(dp_bus.finished), 32'd0);
        lat = 0;
        for (int k = 1; k <= 64; k++) begin
            @(posedge clock); #1;
            if (k == 1) dp_bus.start = 1'b0;
            if (mode == 1 && k == 4) begin
                dp_bus.instruction = {4'd3, 28'h0};
                dp_bus.start = 1'b1;
            end
            if (mode == 1 && k == 7) dp_bus.start = 1'b0;
            if (dp_bus.finished) begin lat = k; break; end
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_result"}, dp_bus.result, exp_res);
        @(posedge clock);
    endtask

    task automatic run_held(input logic [3:0] opc, input logic [27:0] opnd, input string tag);
        logic [31:0] exp_res;
        int          exp_lat;
        model_exec(opc, opnd, exp_res, exp_lat);
        @(negedge clock);
        dp_bus.instruction = {opc, opnd};
        dp_bus.start = 1'b1;
        repeat (10) @(posedge clock);
        #1;
        chk({tag, "_finished"}, 32'(dp_bus.finished), 32'd1);
        chk({tag, "_result"}, dp_bus.result, exp_res);
        dp_bus.start = 1'b0;
        @(posedge clock);
    endtask

    initial begin
        logic [31:0] ignore_res;
        int          ignore_lat;
        resetn = 1'b0;
        dp_bus.start = 1'b0;
        dp_bus.instruction = 32'h0;
        model_reset();

        do_reset("reset0");
        run_op(4'd1, 28'd3, "load_a3", 0);
        run_op(4'd2, 28'h000FFFE, "load_b_m2", 0);
        run_op(4'd3, 28'h0, "clr", 0);
        run_op(4'd5, 28'h0, "mac_3xm2", 0);
        chk("mac_value", m_acc, 32'hFFFF_FFFA);
        run_op(4'd6, 28'h0, "read_mac", 0);

        do_reset("reset1");
        run_op(4'd7, 28'd1, "rand2", 0);
        chk("rand2_value", m_lfsr, 32'hC030_0002);
        do_reset("reset2");
        run_op(4'd7, 28'd0, "rand1", 0);

        run_op(4'd3, 28'h0, "clr2", 0);
        run_op(4'd1, 28'h7FFF, "load_a_max", 0);
        run_op(4'd4, 28'h0, "add1", 0);
        run_op(4'd4, 28'h0, "add2", 0);
        chk("add2_value", m_acc, 32'h0000_FFFE);
        run_op(4'd3, 28'h0, "clr3", 0);
        run_op(4'd1, 28'hFFFF, "load_a_m1", 0);
        run_op(4'd4, 28'h0, "add_m1", 0);
        run_op(4'd1, 28'd1, "load_a_1", 0);
        run_op(4'd4, 28'h0, "add_wrap", 0);
        chk("wrap_value", m_acc, 32'h0);

        run_held(4'd1, 28'h0123, "held_load_a");
        run_held(4'd4, 28'h0, "held_add");
        run_op(4'd6, 28'h0, "read_held", 0);
        run_op(4'd2, 28'h0007, "load_b7", 0);
        run_op(4'd5, 28'h0, "mac_disturbed", 1);
        run_op(4'd6, 28'h0, "read_disturbed", 0);

        run_op(4'd3, 28'h0, "clr4", 0);
        run_op(4'd1, 28'd5, "load_a5", 0);
        run_op(4'd4, 28'h0, "add5", 0);
        model_exec(4'd5, 28'h0, ignore_res, ignore_lat);
        @(negedge clock);
        dp_bus.instruction = {4'd5, 28'h0};
        dp_bus.start = 1'b1;
        @(posedge clock);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clock); #1;
            if (k == 1) dp_bus.start = 1'b0;
        end
        dp_bus.instruction = {4'd1, 28'h0055};
        dp_bus.start = 1'b1;
        resetn = 1'b0;
        @(posedge clock); #1;
        chk("midreset_finished", 32'(dp_bus.finished), 32'd1);
        chk("midreset_result", dp_bus.result, 32'h0);
        resetn = 1'b1;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        chk("held_after_reset_finished", 32'(dp_bus.finished), 32'd1);
        chk("held_after_reset_result", dp_bus.result, 32'h0);
        dp_bus.start = 1'b0;
        @(posedge clock);
        run_op(4'd6, 28'h0, "read_after_reset", 0);

        run_op(4'd2, 28'h0009, "load_b9", 0);
        run_op(4'd1, 28'h0006, "load_a6", 0);
        run_op(4'd4, 28'h0, "add6", 0);
        run_op(4'hC, 28'hABCDEF1, "invalid_c", 0);
        run_op(4'd6, 28'h0, "read_after_invalid", 0);
        run_op(4'd7, 28'd0, "rand_after_invalid", 0);
        run_op(4'd5, 28'h0, "mac_after_invalid", 0);

        for (int i = 0; i < 24; i++) begin
            logic [3:0]  ropc;
            logic [27:0] ropnd;
            ropc  = 4'($urandom_range(0, 15));
            ropnd = 28'($urandom);
            run_op(ropc, ropnd, $sformatf("rand_op%0d_%0d", i, ropc), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
